// File: rtl/countdown_hms_if.sv
// Command and display bundle for countdown_hms. The master drives the load/start/pause
// commands and reads the count. The slave is the counter itself.
interface countdown_hms_if;
  logic       load;
  logic [4:0] load_hh;
  logic [5:0] load_mm;
  logic [5:0] load_ss;
  logic       start;
  logic       pause;
  logic [4:0] hh_out;
  logic [5:0] mm_out;
  logic [5:0] ss_out;
  logic       running;
  logic       done;

  modport master (
    output load, load_hh, load_mm, load_ss, start, pause,
    input  hh_out, mm_out, ss_out, running, done
  );

  modport slave (
    input  load, load_hh, load_mm, load_ss, start, pause,
    output hh_out, mm_out, ss_out, running, done
  );
endinterface

// File: rtl/countdown_hms.sv
// HH:MM:SS countdown timer. A CLK_FREQ-cycle prescaler produces the one-second tick.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN makes the timer restart from the last preset instead of stopping.
module countdown_hms #(
  parameter int unsigned CLK_FREQ = 50000000
) (
  input  logic           clk,
  input  logic           rst_n,
  countdown_hms_if.slave bus
);
  localparam int unsigned   PW         = $clog2(CLK_FREQ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [4:0]    hh, hh_nxt, rl_hh, rl_hh_nxt;
  logic [5:0]    mm, mm_nxt, rl_mm, rl_mm_nxt;
  logic [5:0]    ss, ss_nxt, rl_ss, rl_ss_nxt;
  logic          running_q, running_nxt;
  logic          done_q, done_nxt;
  logic          tick, cnt_zero, hit_zero, rl_zero;

  assign tick     = (state == S_RUN) && (presc == PRESC_LAST);
  assign cnt_zero = (hh == '0) && (mm == '0) && (ss == '0);
  assign hit_zero = tick && (hh == '0) && (mm == '0) && (ss == 6'd1);
  assign rl_zero  = (rl_hh == '0) && (rl_mm == '0) && (rl_ss == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      presc     <= '0;
      hh        <= '0;
      mm        <= '0;
      ss        <= '0;
      rl_hh     <= '0;
      rl_mm     <= '0;
      rl_ss     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      hh        <= hh_nxt;
      mm        <= mm_nxt;
      ss        <= ss_nxt;
      rl_hh     <= rl_hh_nxt;
      rl_mm     <= rl_mm_nxt;
      rl_ss     <= rl_ss_nxt;
      running_q <= running_nxt;
      done_q    <= done_nxt;
    end
  end

  // A start that is asserted in RUN takes priority over pause, so that start blocks the pause.
  always_comb begin
    state_nxt = state;
    if (bus.load) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE, S_PAUSE: if (bus.start && !cnt_zero) state_nxt = S_RUN;
        S_RUN: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (hit_zero && rl_zero) state_nxt = S_DONE;
`else
          if (hit_zero) state_nxt = S_DONE;
`endif
          else if (!bus.start && bus.pause) state_nxt = S_PAUSE;
        end
        S_DONE: state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // The pausing cycle still counts as a full RUN cycle. The prescaler freezes only afterwards.
  always_comb begin
    presc_nxt   = presc;
    hh_nxt      = hh;
    mm_nxt      = mm;
    ss_nxt      = ss;
    rl_hh_nxt   = rl_hh;
    rl_mm_nxt   = rl_mm;
    rl_ss_nxt   = rl_ss;
    done_nxt    = 1'b0;
    running_nxt = (state_nxt == S_RUN);
    if (bus.load) begin
      hh_nxt    = (bus.load_hh > 5'd23) ? 5'd23 : bus.load_hh;
      mm_nxt    = (bus.load_mm > 6'd59) ? 6'd59 : bus.load_mm;
      ss_nxt    = (bus.load_ss > 6'd59) ? 6'd59 : bus.load_ss;
      rl_hh_nxt = hh_nxt;
      rl_mm_nxt = mm_nxt;
      rl_ss_nxt = ss_nxt;
      presc_nxt = '0;
    end else if (state == S_RUN) begin
      presc_nxt = tick ? '0 : presc + 1'b1;
      if (tick) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (cnt_zero) begin
          hh_nxt = rl_hh;
          mm_nxt = rl_mm;
          ss_nxt = rl_ss;
        end else
`endif
        if (ss != '0) begin
          ss_nxt = ss - 6'd1;
        end else begin
          ss_nxt = 6'd59;
          if (mm != '0) begin
            mm_nxt = mm - 6'd1;
          end else begin
            mm_nxt = 6'd59;
            if (hh != '0) hh_nxt = hh - 5'd1;
          end
        end
        done_nxt = hit_zero;
      end
    end
  end

  assign bus.hh_out  = hh;
  assign bus.mm_out  = mm;
  assign bus.ss_out  = ss;
  assign bus.running = running_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_countdown_hms.sv
// Randomized scoreboard bench for countdown_hms (CLK_FREQ = 4). The reference model keeps
// the remaining time as a single seconds total and the RUN-cycle phase within the current second.
module tb_countdown_hms;
  localparam int F = 4;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
  typedef struct {
    int h; int m; int s; bit run; bit done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  countdown_hms_if bus();

  countdown_hms #(.CLK_FREQ(F)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  exp_t exp_q[$];

  mstate_t m_st = M_IDLE;
  int m_secs = 0;
  int m_reload = 0;
  int m_phase = 0;

  function automatic int clampv(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_step(input bit l, input int h, input int m, input int s,
                            input bit st, input bit pa, output bit d);
    mstate_t nxt;
    d = 1'b0;
    if (l) begin
      m_secs   = clampv(h, 23) * 3600 + clampv(m, 59) * 60 + clampv(s, 59);
      m_reload = m_secs;
      m_phase  = 0;
      m_st     = M_IDLE;
    end else if ((m_st == M_IDLE || m_st == M_PAUSE) && st && m_secs != 0) begin
      m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      nxt = (!st && pa) ? M_PAUSE : M_RUN;
      m_phase = m_phase + 1;
      if (m_phase == F) begin
        m_phase = 0;
        if (AUTO && m_secs == 0) begin
          m_secs = m_reload;
        end else begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin
            d = 1'b1;
            if (!AUTO || m_reload == 0) nxt = M_DONE;
          end
        end
      end
      m_st = nxt;
    end
  endtask

  task automatic drive(input bit l, input int h, input int m, input int s,
                       input bit st, input bit pa);
    exp_t e;
    bit d;
    @(negedge clk);
    bus.load    = l;
    bus.load_hh = 5'(h);
    bus.load_mm = 6'(m);
    bus.load_ss = 6'(s);
    bus.start   = st;
    bus.pause   = pa;
    model_step(l, h, m, s, st, pa, d);
    e.h = m_secs / 3600;
    e.m = (m_secs / 60) % 60;
    e.s = m_secs % 60;
    e.run = (m_st == M_RUN);
    e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  // Constant-based spot check, taken just after the edge that follows the last drive.
  task automatic expect_now(input string name, input int h, input int m, input int s, input bit r);
    #6;
    tests++;
    if (bus.hh_out != 5'(h) || bus.mm_out != 6'(m) || bus.ss_out != 6'(s) || bus.running != r) begin
      fails++;
      $display("FAIL %s: got %0d:%0d:%0d run=%b, expected %0d:%0d:%0d run=%b", name,
               bus.hh_out, bus.mm_out, bus.ss_out, bus.running, h, m, s, r);
    end
  endtask

  task automatic check_reset(input string name);
    tests++;
    if (bus.hh_out != '0 || bus.mm_out != '0 || bus.ss_out != '0 || bus.running || bus.done) begin
      fails++;
      $display("FAIL %s: got %0d:%0d:%0d run=%b done=%b, expected 0:0:0 run=0 done=0", name,
               bus.hh_out, bus.mm_out, bus.ss_out, bus.running, bus.done);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    bus.load_hh = '0; bus.load_mm = '0; bus.load_ss = '0;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    m_st = M_IDLE; m_secs = 0; m_reload = 0; m_phase = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: the outputs are registered, so every clock edge presents a new observation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        tests++;
        if (bus.hh_out != 5'(e.h) || bus.mm_out != 6'(e.m) || bus.ss_out != 6'(e.s) ||
            bus.running != e.run || bus.done != e.done) begin
          fails++;
          $display("FAIL cycle %0d outputs: got %0d:%0d:%0d run=%b done=%b, expected %0d:%0d:%0d run=%b done=%b",
                   cyc, bus.hh_out, bus.mm_out, bus.ss_out, bus.running, bus.done,
                   e.h, e.m, e.s, e.run, e.done);
        end
      end
    end
  end

  initial begin
    int r, h, m, s;
    bit l, st, pa;
    bus.load = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    bus.load_hh = '0; bus.load_mm = '0; bus.load_ss = '0;
    #3;
    check_reset("power_on_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 3 seconds to done.
    drive(1, 0, 0, 3, 0, 0); drive(0, 0, 0, 0, 1, 0); idle(14);
    // Clamp of an out-of-range preset.
    drive(1, 31, 63, 60, 0, 0);
    expect_now("clamp", 23, 59, 59, 1'b0);
    // Borrow chains.
    drive(1, 1, 0, 0, 0, 0); drive(0, 0, 0, 0, 1, 0); idle(4);
    expect_now("hour_borrow", 0, 59, 59, 1'b1);
    drive(1, 0, 1, 0, 0, 0); drive(0, 0, 0, 0, 1, 0); idle(4);
    expect_now("minute_borrow", 0, 0, 59, 1'b1);
    // Pause on RUN cycle 6 for 10 cycles, then resume.
    drive(1, 0, 0, 5, 0, 0); drive(0, 0, 0, 0, 1, 0); idle(5);
    drive(0, 0, 0, 0, 0, 1); idle(9); drive(0, 0, 0, 0, 1, 0); idle(2);
    expect_now("resume_phase", 0, 0, 3, 1'b1);
    idle(12);
    // Load during RUN.
    drive(1, 0, 0, 9, 0, 0); drive(0, 0, 0, 0, 1, 0); idle(4);
    drive(1, 0, 2, 0, 0, 0); idle(6);
    // Start with a zero count, and start while DONE.
    drive(1, 0, 0, 0, 0, 0); drive(0, 0, 0, 0, 1, 0); idle(3);
    drive(1, 0, 0, 1, 0, 0); drive(0, 0, 0, 0, 1, 0); idle(5); drive(0, 0, 0, 0, 1, 0); idle(3);
    // 2-second countdown (this exercises the reload when it is enabled).
    drive(1, 0, 0, 2, 0, 0); drive(0, 0, 0, 0, 1, 0); idle(26);
    // Reset in the middle of RUN.
    drive(1, 0, 0, 4, 0, 0); drive(0, 0, 0, 0, 1, 0); idle(6);
    do_reset();
    idle(3);

    for (int i = 0; i < 2500; i++) begin
      if (i % 900 == 450) do_reset();
      r  = int'($urandom_range(0, 999));
      l  = (r < 8);
      st = (r >= 8 && r < 90);
      pa = (r >= 90 && r < 120);
      h = 0; m = 0; s = 0;
      if (l) begin
        h = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : 0;
        m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : 0;
        s = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 12));
      end
      drive(l, h, m, s, st, pa);
    end

    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
